// File: rtl/cronometro_pkg.sv
// cronometro_pkg: shared state type, digit geometry and BCD step helper for the stopwatch.
package cronometro_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} crono_state_t;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;

    // Returns {carry_out, next_digit}; the digit passes through unchanged without carry_in.
    function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] d, input logic cin);
        return cin ? ((d == BCD_W'(9)) ? {1'b1, BCD_W'(0)} : {1'b0, d + BCD_W'(1)}) : {1'b0, d};
    endfunction

endpackage

// File: rtl/cronometro_ctrl_if.sv
// cronometro_ctrl_if: raw KEY inputs toward the controller and display/status outputs back.
interface cronometro_ctrl_if;

    logic        btn_start_n;
    logic        btn_lap_n;
    logic        btn_clear_n;
    logic [15:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        ovf;
    logic        tick;

    modport master (
        output btn_start_n, btn_lap_n, btn_clear_n,
        input  disp_bcd, running, lap_active, ovf, tick
    );

    modport slave (
        input  btn_start_n, btn_lap_n, btn_clear_n,
        output disp_bcd, running, lap_active, ovf, tick
    );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF sync of an active-low button, level debounce, 1-cycle pulse on accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff = r_sync[1] != r_level;
    assign w_done = w_diff && r_cnt == CW'(DEBOUNCE_CYC - 1);

    // Sync stages reset to released so leaving reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_level     <= 1'b1;
            r_cnt       <= '0;
            press_pulse <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], btn_n};
            r_cnt       <= (w_diff && !w_done) ? r_cnt + CW'(1) : '0;
            r_level     <= w_done ? r_sync[1] : r_level;
            press_pulse <= w_done && !r_sync[1];
        end
    end

endmodule

// File: rtl/cronometro_ctrl.sv
// cronometro_ctrl: stopwatch FSM, tick prescaler, 4-digit BCD count with lap latch and overflow flag.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int TICK_DIV     = 500000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input logic               clk,
    input logic               rst,
    cronometro_ctrl_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = BCD_W * NUM_DIGITS;

    crono_state_t      r_state;
    crono_state_t      w_next;
    logic [PW-1:0]     r_presc;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_latch;
    logic [CW-1:0]     r_disp;
    logic              r_ovf;
    logic [CW-1:0]     w_count_inc;
    logic [NUM_DIGITS:0] w_carry;
    logic              w_live;
    logic              w_tick;
    logic              w_start;
    logic              w_lap;
    logic              w_clear;
    logic              w_to_idle;
    logic              w_take_lap;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (.clk(clk), .rst(rst), .btn_n(bus.btn_start_n), .press_pulse(w_start));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_lap   (.clk(clk), .rst(rst), .btn_n(bus.btn_lap_n),   .press_pulse(w_lap));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (.clk(clk), .rst(rst), .btn_n(bus.btn_clear_n), .press_pulse(w_clear));

    assign w_live  = r_state == RUN || r_state == LAP;
    assign w_tick  = w_live && r_presc == PW'(TICK_DIV - 1);

    assign w_carry[0] = 1'b1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        assign {w_carry[g+1], w_count_inc[g*BCD_W +: BCD_W]} = bcd_inc(r_count[g*BCD_W +: BCD_W], w_carry[g]);
    end

    // Start outranks everything; clear only matters in PAUSE, so lap acts in RUN/LAP unless start is present.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? RUN : IDLE;
            RUN:     w_next = w_start ? PAUSE : w_lap ? LAP : RUN;
            LAP:     w_next = w_start ? PAUSE : w_lap ? RUN : LAP;
            PAUSE:   w_next = w_start ? RUN : w_clear ? IDLE : PAUSE;
            default: w_next = IDLE;
        endcase
    end

    assign w_to_idle  = r_state == PAUSE && w_next == IDLE;
    assign w_take_lap = r_state == RUN && w_next == LAP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_count <= '0;
            r_latch <= '0;
            r_disp  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_presc <= (r_state == IDLE || w_to_idle) ? '0 : w_live ? (w_tick ? '0 : r_presc + PW'(1)) : r_presc;
            r_count <= w_to_idle ? '0 : w_tick ? w_count_inc : r_count;
            r_ovf   <= !w_to_idle && (r_ovf || (w_tick && w_carry[NUM_DIGITS]));
            r_latch <= w_take_lap ? r_count : r_latch;
            r_disp  <= (r_state == LAP) ? r_latch : r_count;
        end
    end

    assign bus.disp_bcd   = r_disp;
    assign bus.running    = w_live;
    assign bus.lap_active = r_state == LAP;
    assign bus.ovf        = r_ovf;
    assign bus.tick       = w_tick;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// tb_cronometro_ctrl: directed timeline with literal checkpoints plus random button traffic,
// every cycle compared against an integer-count reference model of the stopwatch.
module tb_cronometro_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cronometro_ctrl_if bus();

    cronometro_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    int nt = 0;
    int nt0 = 0;

    int       m_st, m_cnt, m_latch, m_disp, m_presc, m_old, m_nd, m_ns;
    bit       m_ovf, m_tk;
    bit [7:0] m_h [3];
    bit       m_lvl [3];
    bit       m_ev [3];
    bit       m_raw [3];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: count is a plain integer 0..9999; a button press is accepted once the synced
    // samples seen over the last DB edges all disagree with the accepted level.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_st = S_IDLE; m_cnt = 0; m_latch = 0; m_disp = 0; m_presc = 0; m_ovf = 0;
            for (int b = 0; b < 3; b++) begin
                m_h[b] = 8'hFF; m_lvl[b] = 1'b1; m_ev[b] = 1'b0;
            end
        end else begin
            m_raw[0] = bus.btn_start_n; m_raw[1] = bus.btn_clear_n; m_raw[2] = bus.btn_lap_n;
            m_tk  = (m_st == S_RUN || m_st == S_LAP) && m_presc == TD - 1;
            m_nd  = (m_st == S_LAP) ? m_latch : m_cnt;
            m_old = m_cnt;
            if (m_tk) begin
                m_cnt = (m_cnt + 1) % 10000;
                if (m_cnt == 0) m_ovf = 1'b1;
            end
            if (m_st == S_IDLE) m_presc = 0;
            else if (m_st != S_PAUSE) m_presc = (m_presc + 1) % TD;
            m_ns = m_st;
            case (m_st)
                S_IDLE:  if (m_ev[0]) m_ns = S_RUN;
                S_RUN:   if (m_ev[0]) m_ns = S_PAUSE; else if (m_ev[2]) begin m_ns = S_LAP; m_latch = m_old; end
                S_LAP:   if (m_ev[0]) m_ns = S_PAUSE; else if (m_ev[2]) m_ns = S_RUN;
                default: if (m_ev[0]) m_ns = S_RUN; else if (m_ev[1]) begin m_ns = S_IDLE; m_cnt = 0; m_ovf = 0; m_presc = 0; end
            endcase
            m_st = m_ns;
            m_disp = m_nd;
            for (int b = 0; b < 3; b++) begin
                bit acc;
                m_h[b] = {m_h[b][6:0], m_raw[b]};
                acc = 1'b1;
                for (int k = 2; k <= DB + 1; k++) if (m_h[b][k] == m_lvl[b]) acc = 1'b0;
                m_ev[b] = acc && m_lvl[b];
                if (acc) m_lvl[b] = !m_lvl[b];
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc - base);
        end
    endtask

    task automatic next_edge();
        logic [15:0] e_disp;
        logic e_run, e_lap, e_tick;
        @(posedge clk);
        #2;
        if (!rst) begin
            e_disp = to_bcd(m_disp);
            e_run  = m_st == S_RUN || m_st == S_LAP;
            e_lap  = m_st == S_LAP;
            e_tick = e_run && m_presc == TD - 1;
            checks++;
            if (bus.disp_bcd !== e_disp || bus.running !== e_run || bus.lap_active !== e_lap ||
                bus.ovf !== m_ovf || bus.tick !== e_tick) begin
                errors++;
                $display("FAIL model cycle %0d: disp %h/%h run %b/%b lap %b/%b ovf %b/%b tick %b/%b (got/expected)",
                         cyc - base, bus.disp_bcd, e_disp, bus.running, e_run, bus.lap_active, e_lap,
                         bus.ovf, m_ovf, bus.tick, e_tick);
            end
            if (bus.tick) nt++;
        end
    endtask

    task automatic at_edge(input int n);
        while (cyc < base + n) next_edge();
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        bus.btn_start_n = 1'b1; bus.btn_lap_n = 1'b1; bus.btn_clear_n = 1'b1;
        #1;
        chk("rst_disp", bus.disp_bcd, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_lap", bus.lap_active, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_tick", bus.tick, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        base = cyc;
    endtask

    initial begin
        bus.btn_start_n = 1'b1; bus.btn_lap_n = 1'b1; bus.btn_clear_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        do_reset();
        bus.btn_start_n = 1'b0;
        for (int i = 0; i < 6 && !bus.running; i++) next_edge();
        chk("start_latency", bus.running, 1);
        at_edge(6);
        nt0 = nt;
        at_edge(10); bus.btn_start_n = 1'b1;
        at_edge(12); bus.btn_lap_n = 1'b0;
        at_edge(14); bus.btn_lap_n = 1'b1;
        at_edge(20); chk("glitch_no_lap", bus.lap_active, 0);
        at_edge(22); bus.btn_lap_n = 1'b0;
        at_edge(30); bus.btn_lap_n = 1'b1;
        chk("lap_frozen", bus.disp_bcd, 16'h0005);
        chk("lap_active", bus.lap_active, 1);
        at_edge(40); chk("lap_still_frozen", bus.disp_bcd, 16'h0005);
        bus.btn_lap_n = 1'b0;
        at_edge(46); bus.btn_lap_n = 1'b1;
        chk("tick_rate", nt - nt0, 10);
        at_edge(47);
        chk("lap_exit_live", bus.disp_bcd, 16'h0010);
        chk("lap_exit_flag", bus.lap_active, 0);
        chk("lap_exit_run", bus.running, 1);
        at_edge(50); bus.btn_start_n = 1'b0;
        at_edge(55); bus.btn_start_n = 1'b1;
        at_edge(62);
        chk("pause_disp", bus.disp_bcd, 16'h0012);
        chk("pause_running", bus.running, 0);
        bus.btn_start_n = 1'b0;
        at_edge(68);
        chk("resume_run", bus.running, 1);
        chk("resume_no_tick", bus.tick, 0);
        bus.btn_start_n = 1'b1;
        at_edge(69); chk("resume_frac_tick", bus.tick, 1);
        at_edge(72); bus.btn_start_n = 1'b0;
        at_edge(78); bus.btn_start_n = 1'b1;
        at_edge(80); bus.btn_clear_n = 1'b0;
        at_edge(86); bus.btn_clear_n = 1'b1;
        at_edge(88);
        chk("clear_disp", bus.disp_bcd, 0);
        chk("clear_ovf", bus.ovf, 0);
        chk("clear_idle", bus.running, 0);
        at_edge(90);  bus.btn_start_n = 1'b0;
        at_edge(96);  bus.btn_start_n = 1'b1;
        at_edge(110); bus.btn_start_n = 1'b0;
        at_edge(116); bus.btn_start_n = 1'b1;
        at_edge(120); bus.btn_start_n = 1'b0; bus.btn_clear_n = 1'b0;
        at_edge(126); bus.btn_start_n = 1'b1; bus.btn_clear_n = 1'b1;
        at_edge(127);
        chk("start_beats_clear", bus.running, 1);
        chk("count_retained", bus.disp_bcd, 16'h0005);
        at_edge(40108);
        chk("wrap_disp", bus.disp_bcd, 0);
        chk("wrap_ovf", bus.ovf, 1);
        at_edge(40110); bus.btn_clear_n = 1'b0;
        at_edge(40116); bus.btn_clear_n = 1'b1;
        at_edge(40120);
        chk("clear_in_run_ovf", bus.ovf, 1);
        chk("clear_in_run_running", bus.running, 1);
        at_edge(40125);
        do_reset();
        repeat (300) begin
            int mask;
            mask = $urandom_range(0, 7);
            bus.btn_start_n = !mask[0]; bus.btn_clear_n = !mask[1]; bus.btn_lap_n = !mask[2];
            repeat ($urandom_range(1, 8)) next_edge();
            bus.btn_start_n = 1'b1; bus.btn_clear_n = 1'b1; bus.btn_lap_n = 1'b1;
            repeat ($urandom_range(1, 12)) next_edge();
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
